// File: rtl/irrigation_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : irrigation_sequencer
// Description : Debounces the six field sensors, validates the tank level
//               sensors and sequences the fill valve, sprinkler pump and
//               dripper valve with min/max run times, a fill timeout and a
//               latched alarm with operator clear.
// Revision    : 1.0 - initial release
// ============================================================================
module irrigation_sequencer #(
  parameter int DEBOUNCE     = 4,
  parameter int MIN_ON       = 8,
  parameter int MAX_ON       = 64,
  parameter int REST_TIME    = 16,
  parameter int FILL_TIMEOUT = 128,
  parameter int CW           = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       low_water_level,
  input  logic       mid_water_level,
  input  logic       high_water_level,
  input  logic       earth_humidity,
  input  logic       air_humidity,
  input  logic       low_temperature,
  input  logic       alarm_clear,
  output logic       water_supply_valvule,
  output logic       splinker_bomb,
  output logic       dripper_valvule,
  output logic       alarm,
  output logic [2:0] state_dbg
);

  // Timer thresholds are expressed as "last cycle in state" values: the
  // decision taken on the cycle where the timer equals X-1 leaves after
  // exactly X cycles in the state.
  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] MIN_LAST   = CW'(MIN_ON - 1);
  localparam logic [CW-1:0] MAX_LAST   = CW'(MAX_ON - 1);
  localparam logic [CW-1:0] REST_LAST  = CW'(REST_TIME - 1);
  localparam logic [CW-1:0] FILL_LAST  = CW'(FILL_TIMEOUT - 1);
  localparam logic [CW-1:0] TIMER_SAT  = {CW{1'b1}};
  localparam logic [CW-1:0] ONE        = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FILL     = 3'd1,
    S_SPRINKLE = 3'd2,
    S_DRIP     = 3'd3,
    S_REST     = 3'd4,
    S_FAULT    = 3'd5
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] timer;
  logic          refill;
  logic          refill_next;
  logic          irr_next;

  // Bit order of the sensor vectors: {temp, air, earth, high, mid, low}
  logic [5:0] raw;
  logic [5:0] filt;

  assign raw = {low_temperature, air_humidity, earth_humidity,
                high_water_level, mid_water_level, low_water_level};

  generate
    for (genvar i = 0; i < 6; i++) begin : g_debounce
      logic [CW-1:0] cnt;
      logic          fval;

      assign filt[i] = fval;

      // Filtered value follows raw only after DEBOUNCE consecutive mismatches
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt  <= '0;
          fval <= 1'b0;
        end else if (raw[i] == fval) begin
          cnt <= '0;
        end else if (cnt == DB_LAST) begin
          fval <= raw[i];
          cnt  <= '0;
        end else begin
          cnt <= cnt + ONE;
        end
      end
    end
  endgenerate

  logic low_f, mid_f, high_f, earth_f, air_f, temp_f;
  logic lvl_err;

  assign low_f   = filt[0];
  assign mid_f   = filt[1];
  assign high_f  = filt[2];
  assign earth_f = filt[3];
  assign air_f   = filt[4];
  assign temp_f  = filt[5];

  // A higher mark wet while a lower one is dry means a broken level sensor
  assign lvl_err = (mid_f & ~low_f) | (high_f & ~mid_f);

  // Next-state decision; level error has top priority outside FAULT
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (lvl_err)
          next_state = S_FAULT;
        else if (!high_f)
          next_state = S_FILL;
        else if (!earth_f && low_f)
          next_state = (!air_f && !temp_f && mid_f) ? S_SPRINKLE : S_DRIP;
      end
      S_FILL: begin
        if (lvl_err)
          next_state = S_FAULT;
        else if (high_f)
          next_state = S_IDLE;
        else if (timer >= FILL_LAST)
          next_state = S_FAULT;
      end
      S_SPRINKLE, S_DRIP: begin
        if (lvl_err)
          next_state = S_FAULT;
        else if (timer >= MAX_LAST)
          next_state = S_REST;
        else if ((timer >= MIN_LAST) && (earth_f || !low_f))
          next_state = S_IDLE;
      end
      S_REST: begin
        if (lvl_err)
          next_state = S_FAULT;
        else if (timer >= REST_LAST)
          next_state = S_IDLE;
      end
      S_FAULT: begin
        if (alarm_clear && !lvl_err)
          next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Refill during irrigation opens below mid and holds until high or exit
  assign irr_next    = (next_state == S_SPRINKLE) || (next_state == S_DRIP);
  assign refill_next = irr_next && !high_f && (!mid_f || refill);

  // State, shared saturating timer and outputs registered from next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= S_IDLE;
      timer                <= '0;
      refill               <= 1'b0;
      water_supply_valvule <= 1'b0;
      splinker_bomb        <= 1'b0;
      dripper_valvule      <= 1'b0;
      alarm                <= 1'b0;
    end else begin
      state  <= next_state;
      refill <= refill_next;
      if (next_state != state)
        timer <= '0;
      else if (timer != TIMER_SAT)
        timer <= timer + ONE;
      water_supply_valvule <= (next_state == S_FILL) || refill_next;
      splinker_bomb        <= (next_state == S_SPRINKLE);
      dripper_valvule      <= (next_state == S_DRIP);
      alarm                <= (next_state == S_FAULT);
    end
  end

  assign state_dbg = state;

endmodule
`default_nettype wire

// File: doc/irrigation_sequencer.md
Name: irrigation_sequencer

Overview:
Sequenced, clocked replacement for the purely combinational irrigation decision path. Debounces the six field sensors, validates the water-tank level sensors and runs one FSM that owns the tank fill valve, sprinkler pump and dripper valve. Adds minimum/maximum run times, a fill timeout and a latched alarm with operator clear. Outputs are mutually exclusive between the irrigation modes and are all registered.

Parameters:
DEBOUNCE, 4, cycles a raw sensor must hold a new value before the filtered value changes (legal range 1..255).
MIN_ON, 8, minimum cycles SPRINKLE or DRIP stays active once entered.
MAX_ON, 64, cycles after which irrigation is forced off and the FSM goes to REST (MAX_ON > MIN_ON).
REST_TIME, 16, cycles the FSM stays in REST before irrigation may restart.
FILL_TIMEOUT, 128, cycles in FILL without reaching high level before alarm.
CW, 8, counter width; every parameter value must be < 2^CW.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high; clears all state.
low_water_level  input  1  raw tank sensor; 1 = water at or above the low mark.
mid_water_level  input  1  raw; 1 = at or above the mid mark.
high_water_level  input  1  raw; 1 = at or above the high mark.
earth_humidity  input  1  raw; 1 = soil wet.
air_humidity  input  1  raw; 1 = air humid.
low_temperature  input  1  raw; 1 = cold.
alarm_clear  input  1  operator acknowledge, level-sampled.
water_supply_valvule  output  1  tank fill valve open.
splinker_bomb  output  1  sprinkler pump on.
dripper_valvule  output  1  dripper valve open.
alarm  output  1  latched fault indicator.
state_dbg  output  3  current FSM state encoding.

Behaviour:
- Reset: all outputs 0, state IDLE (0), all counters 0, each filtered sensor = 0.
- Debounce: one counter per sensor; filtered value updates when raw != filtered for DEBOUNCE consecutive cycles. Counter clears on any cycle where raw == filtered. Filtered value is seen by the FSM one cycle after the update.
- Level error (combinational on filtered levels): (mid & ~low) | (high & ~mid).
- State encodings: IDLE=0, FILL=1, SPRINKLE=2, DRIP=3, REST=4, FAULT=5.
- Transition priority, evaluated each cycle from any non-FAULT state: level error -> FAULT.
- IDLE:
  - ~high -> FILL.
  - Else earth dry (earth_humidity=0) & low: if ~air_humidity & ~low_temperature & mid -> SPRINKLE, else -> DRIP.
  - Else stay.
- FILL: water_supply_valvule=1.
  - high -> IDLE.
  - Timer reaching FILL_TIMEOUT -> FAULT.
- SPRINKLE: splinker_bomb=1. DRIP: dripper_valvule=1.
  - Run timer counts from entry.
  - Before MIN_ON, exit only on level error.
  - At or after MIN_ON, exit to IDLE on earth wet or ~low.
  - Timer reaching MAX_ON -> REST.
  - No direct SPRINKLE<->DRIP switching.
- Tank refill during irrigation: fill valve also opens in SPRINKLE/DRIP while ~mid. It closes at high or on leaving the state.
- REST: outputs 0; after REST_TIME cycles -> IDLE.
- FAULT: alarm=1, all actuators 0.
  - Exit to IDLE only when alarm_clear=1 and no level error in the same cycle.
  - alarm_clear while the error persists is ignored.
- Outputs are registered from next state: actuator changes are visible the cycle after the transition decision.
- Counters:
  - The shared state timer clears on every state change.
  - It saturates at 2^CW-1 and never wraps.
- Reset mid-operation: asserting reset drops all actuators immediately (asynchronous), regardless of state.

Test Plan:
- Reset, then all raw sensors 0 -> after DEBOUNCE+2 cycles state FILL and water_supply_valvule=1. Raise low, mid, high in order, each held ≥ DEBOUNCE -> IDLE and valve 0.
- Tank full, earth=0, air=0, temp=0 -> SPRINKLE, splinker_bomb=1. Set earth=1 at cycle 3 -> pump stays on until MIN_ON=8, then IDLE.
- Tank full, earth=0, air=1 held -> DRIP. Keep earth=0 -> at cycle 64 dripper 0 and state REST for 16 cycles, then DRIP again.
- Raw high glitches 1 for DEBOUNCE-1 cycles while mid=0 -> no alarm. Hold high=1, mid=0 for DEBOUNCE cycles -> FAULT, alarm=1, actuators 0. Pulse alarm_clear during error -> still FAULT; fix sensors and clear -> IDLE.
- Levels stuck low=1, mid=1, high=0 -> FILL for 128 cycles -> FAULT, alarm=1.
- Assert reset mid-SPRINKLE -> splinker_bomb=0 and state_dbg=0 without a clock edge.
